// File: rtl/pll_reset_manager_pkg.sv
// Shared definitions for the PLL lock-qualified reset manager.
// State encoding, loss counter width and a saturating increment helper.
package pll_reset_manager_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } prm_state_t;

    localparam int LOCK_LOSS_W = 8;

    function automatic logic [LOCK_LOSS_W-1:0] sat_inc(
        input logic [LOCK_LOSS_W-1:0] v
    );
        return (v == '1) ? v : v + LOCK_LOSS_W'(1);
    endfunction

endpackage

// File: rtl/pll_reset_manager_clk_en_div.sv
// Clock-enable divider: one-cycle strobe every div cycles while run is high.
// A divisor of 0 behaves as 1; the counter parks at 0 outside run.
module clk_en_div #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             en
);

    logic [DIV_W-1:0] ctr;
    logic [DIV_W-1:0] last;

    assign last = (div == '0) ? '0 : div - DIV_W'(1);
    assign en   = run && (ctr == last);

    // Free-running phase counter, realigned to 0 whenever run drops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctr <= '0;
        end else if (!run || en) begin
            ctr <= '0;
        end else begin
            ctr <= ctr + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pll_reset_manager.sv
// Lock-qualified reset and clock-enable generator behind a board PLL.
// Synchronizes locked, qualifies it, stretches reset, counts lock losses.
module pll_reset_manager
    import pll_reset_manager_pkg::*;
#(
    parameter int                      LOCK_CYCLES = 1024,
    parameter int                      HOLD_CYCLES = 16,
    parameter int                      NUM_EN      = 2,
    parameter int                      DIV_W       = 16,
    parameter logic [NUM_EN*DIV_W-1:0] DIVS        = {16'd2, 16'd20}
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   locked,
    output logic                   rst_out_n,
    output logic                   ready,
    output logic [NUM_EN-1:0]      en,
    output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

    localparam int CNT_MAX =
        (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic       sync1;
    logic       lk;
    prm_state_t state;
    prm_state_t state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic       loss;
    logic       run_nxt;

    // Two-flop synchronizer for the asynchronous PLL lock flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= locked;
            lk    <= sync1;
        end
    end

    // State, qualification counter and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            rst_out_n     <= 1'b0;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rst_out_n <= run_nxt;
            ready     <= run_nxt;
            if (loss) begin
                lock_loss_cnt <= sat_inc(lock_loss_cnt);
            end
        end
    end

    // Next-state: qualify lock, hold reset, drop back on any loss
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        loss      = 1'b0;
        unique case (state)
            WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                    loss      = 1'b1;
                end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                    loss      = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
    end

    // Output decode: reset release and ready follow the next state
    always_comb begin
        run_nxt = (state_nxt == RUN);
    end

    // One divider per enable channel, all phase-aligned to RUN entry
    for (genvar i = 0; i < NUM_EN; i++) begin : g_en
        clk_en_div #(
            .DIV_W (DIV_W)
        ) u_div (
            .clock   (clock),
            .reset_n (reset_n),
            .run     (ready),
            .div     (DIVS[i*DIV_W +: DIV_W]),
            .en      (en[i])
        );
    end

endmodule

// File: tb/tb_pll_reset_manager.sv
// Scoreboard bench for pll_reset_manager.
// Two instances: divisors {5,3} and {5,0}.
module tb_pll_reset_manager;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       locked;
    logic       rst_a, rdy_a, rst_b, rdy_b;
    logic [1:0] en_a, en_b;
    logic [7:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] q_a[$];
    logic [11:0] q_b[$];

    always #5 clock = ~clock;

    pll_reset_manager #(
        .LOCK_CYCLES (8),
        .HOLD_CYCLES (4),
        .NUM_EN      (2),
        .DIV_W       (16),
        .DIVS        ({16'd5, 16'd3})
    ) u_dut_a (
        .clock         (clock),
        .reset_n       (reset_n),
        .locked        (locked),
        .rst_out_n     (rst_a),
        .ready         (rdy_a),
        .en            (en_a),
        .lock_loss_cnt (cnt_a)
    );

    pll_reset_manager #(
        .LOCK_CYCLES (8),
        .HOLD_CYCLES (4),
        .NUM_EN      (2),
        .DIV_W       (16),
        .DIVS        ({16'd5, 16'd0})
    ) u_dut_b (
        .clock         (clock),
        .reset_n       (reset_n),
        .locked        (locked),
        .rst_out_n     (rst_b),
        .ready         (rdy_b),
        .en            (en_b),
        .lock_loss_cnt (cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_idle(input int loss);
        return {4'b0000, 8'(loss)};
    endfunction

    function automatic logic [11:0] exp_run(input int c, input int loss,
                                            input int d0, input int d1);
        logic e0, e1;
        e0 = ((c % d0) == 0);
        e1 = ((c % d1) == 0);
        return {1'b1, 1'b1, e1, e0, 8'(loss)};
    endfunction

    task automatic push_idle(input int n, input int loss, input bit both);
        for (int i = 0; i < n; i++) begin
            q_a.push_back(exp_idle(loss));
            if (both) q_b.push_back(exp_idle(loss));
        end
    endtask

    task automatic push_run(input int c0, input int n, input int loss,
                            input bit both);
        for (int c = c0; c < c0 + n; c++) begin
            q_a.push_back(exp_run(c, loss, 3, 5));
            if (both) q_b.push_back(exp_run(c, loss, 1, 5));
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_cmp(input string tag, input bit both);
        logic [11:0] e;
        e = q_a.pop_front();
        check({tag, "_a"}, 32'({rst_a, rdy_a, en_a, cnt_a}), 32'(e));
        if (both) begin
            e = q_b.pop_front();
            check({tag, "_b"}, 32'({rst_b, rdy_b, en_b, cnt_b}), 32'(e));
        end
    endtask

    task automatic drain(input string tag, input bit both);
        while (q_a.size() > 0) begin
            step();
            pop_cmp(tag, both);
        end
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        locked  = 1'b0;
        repeat (3) step();
        push_idle(1, 0, 1'b1);
        pop_cmp(tag, 1'b1);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int loss;
        reset_n = 1'b0;
        locked  = 1'b0;

        // 1: clean lock, release after edge 14, enable phasing
        do_reset("t1_reset");
        locked = 1'b1;
        push_idle(14, 0, 1'b0);
        push_run(1, 30, 0, 1'b0);
        drain("t1_run", 1'b0);

        // 2: two-cycle glitch during STABLE restarts qualification
        do_reset("t2_reset");
        locked = 1'b1;
        push_idle(4, 0, 1'b0);
        drain("t2_stable", 1'b0);
        locked = 1'b0;
        push_idle(2, 0, 1'b0);
        drain("t2_glitch", 1'b0);
        locked = 1'b1;
        push_idle(14, 0, 1'b0);
        push_run(1, 10, 0, 1'b0);
        drain("t2_run", 1'b0);

        // 3: loss in RUN, then relock with realigned phase
        locked = 1'b0;
        push_run(11, 2, 0, 1'b0);
        push_idle(1, 1, 1'b0);
        push_idle(3, 1, 1'b0);
        drain("t3_loss", 1'b0);
        locked = 1'b1;
        push_idle(14, 1, 1'b0);
        push_run(1, 20, 1, 1'b0);
        drain("t3_relock", 1'b0);

        // 4: loss during HOLD, reset never released
        locked = 1'b0;
        push_run(21, 2, 1, 1'b0);
        push_idle(4, 2, 1'b0);
        drain("t4_drop", 1'b0);
        locked = 1'b1;
        push_idle(10, 2, 1'b0);
        drain("t4_qual", 1'b0);
        locked = 1'b0;
        push_idle(2, 2, 1'b0);
        push_idle(21, 3, 1'b0);
        drain("t4_hold", 1'b0);

        // 5: 300 RUN losses saturate the counter
        loss = 3;
        for (int i = 0; i < 300; i++) begin
            locked = 1'b1;
            push_idle(14, loss, 1'b0);
            push_run(1, 2, loss, 1'b0);
            drain("t5_up", 1'b0);
            locked = 1'b0;
            push_run(3, 2, loss, 1'b0);
            loss = (loss < 255) ? loss + 1 : 255;
            push_idle(1, loss, 1'b0);
            drain("t5_loss", 1'b0);
        end
        check("t5_sat", 32'(cnt_a), 32'd255);

        // 6: async reset mid-RUN, divisor 0 acts as 1 on instance b
        locked = 1'b1;
        push_idle(14, 255, 1'b1);
        push_run(1, 4, 255, 1'b1);
        drain("t6_up", 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        push_idle(1, 0, 1'b1);
        pop_cmp("t6_async", 1'b1);
        push_idle(2, 0, 1'b1);
        drain("t6_inrst", 1'b1);
        reset_n = 1'b1;
        push_idle(14, 0, 1'b1);
        push_run(1, 12, 0, 1'b1);
        drain("t6_relock", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
